hs4_arbiter: RTL and testbench



---
 rtl/hs4_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_hs4_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs4_arbiter.sv
`timescale 1ns/1ps
// hs4_arbiter
// Round-robin arbiter sharing one four-phase (return-to-zero) bundled-data
// channel between N synchronous requesters. The winner's data is registered
// onto hs_data, hs_req is driven through req+ ack+ req- ack-, and the end of
// the transaction (normal or timed out) is reported with done/err.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      per-requester request, held until that requester's done pulse
//   data     requester i's data in data[i*DW +: DW]
//   grant    one-hot owner of the channel (registered)
//   done     one-cycle pulse when the granted transaction ends
//   err      one-cycle pulse with done when the transaction timed out
//   busy     high whenever the FSM is not idle
//   hs_req   four-phase request to the asynchronous channel (from a flop)
//   hs_data  bundled data, registered, captured at grant time
//   hs_ack   asynchronous acknowledge from the channel
module hs4_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] data,
    output logic [N-1:0]    grant,
    output logic            done,
    output logic            err,
    output logic            busy,
    output logic            hs_req,
    output logic [DW-1:0]   hs_data,
    input  logic            hs_ack
);

    localparam int unsigned PW = $clog2(N);
    // A disabled timeout still needs a one-bit counter to stay legal.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        REQ_HI = 3'd2,
        REQ_LO = 3'd3,
        DONE   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [N-1:0]           grant_q, grant_d;
    logic [DW-1:0]          hs_data_q, hs_data_d;
    logic                   hs_req_q, hs_req_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   to_flag_q, to_flag_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PW-1:0]          win_q, win_d;
    logic                   done_q, err_q, busy_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   win_found_s;
    logic [PW-1:0]          win_idx_s;

    assign ack_s   = sync_q[SYNC_STAGES-1];
    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign hs_req  = hs_req_q;
    assign hs_data = hs_data_q;

    // Synchroniser chain bringing the asynchronous acknowledge into clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], hs_ack};
        end
    end

    // Round-robin search: first set request bit upward from ptr+1, wrapping.
    always_comb begin
        int unsigned idx_v;
        idx_v       = 0;
        win_found_s = 1'b0;
        win_idx_s   = {PW{1'b0}};
        for (int k = 1; k <= int'(N); k++) begin
            idx_v       = (int'(ptr_q) + k) % int'(N);
            win_idx_s   = (!win_found_s && req[idx_v]) ? PW'(idx_v) : win_idx_s;
            win_found_s = win_found_s | req[idx_v];
        end
    end

    // Next-state and datapath decode of the handshake FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hs_data_d = hs_data_q;
        hs_req_d  = hs_req_q;
        cnt_d     = cnt_q;
        to_flag_d = to_flag_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        case (state_q)
            IDLE: begin
                // A channel still returning to zero must not see a new request.
                if (win_found_s && !ack_s) begin
                    grant_d   = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
                    hs_data_d = data[win_idx_s*DW +: DW];
                    win_d     = win_idx_s;
                    state_d   = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                // Data has been stable for a full cycle before req rises.
                hs_req_d = 1'b1;
                cnt_d    = {CW{1'b0}};
                state_d  = REQ_HI;
            end
            REQ_HI: begin
                if (ack_s) begin
                    hs_req_d = 1'b0;
                    state_d  = REQ_LO;
                end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
                    to_flag_d = 1'b1;
                    hs_req_d  = 1'b0;
                    state_d   = REQ_LO;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            REQ_LO: begin
                // No timeout here: the channel must fully return to zero.
                if (!ack_s) begin
                    state_d = DONE;
                end else begin
                    state_d = REQ_LO;
                end
            end
            DONE: begin
                ptr_d     = win_q;
                grant_d   = {N{1'b0}};
                to_flag_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                grant_d   = {N{1'b0}};
                hs_req_d  = 1'b0;
                to_flag_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= {N{1'b0}};
            hs_data_q <= {DW{1'b0}};
            hs_req_q  <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            to_flag_q <= 1'b0;
            ptr_q     <= PW'(N - 1);
            win_q     <= {PW{1'b0}};
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            hs_data_q <= hs_data_d;
            hs_req_q  <= hs_req_d;
            cnt_q     <= cnt_d;
            to_flag_q <= to_flag_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            // DONE lasts exactly one cycle, so these become one-cycle pulses.
            done_q    <= (state_d == DONE);
            err_q     <= (state_d == DONE) && to_flag_d;
            busy_q    <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_hs4_arbiter.sv
`timescale 1ns/1ps
module tb_hs4_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int S  = 2;
    localparam int T  = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [N-1:0]    grant;
    logic            done, err, busy, hs_req;
    logic [DW-1:0]   hs_data;
    logic            hs_ack;

    // Channel model: 0 = ack follows req with zero delay, 1 = never acks,
    // 2 = ack follows req but is held high 50 cycles after req falls.
    int   ack_mode = 0;
    logic ack_hold = 1'b0;
    int   hold_cnt = 0;

    hs4_arbiter #(.N(N), .DW(DW), .SYNC_STAGES(S), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant),
        .done(done), .err(err), .busy(busy), .hs_req(hs_req),
        .hs_data(hs_data), .hs_ack(hs_ack)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (ack_mode)
            0:       hs_ack = hs_req;
            1:       hs_ack = 1'b0;
            default: hs_ack = hs_req | ack_hold;
        endcase
    end

    always @(posedge clk) begin
        #2;
        if (ack_mode == 2) begin
            if (hs_req) begin
                ack_hold = 1'b1;
                hold_cnt = 0;
            end else if (ack_hold) begin
                hold_cnt++;
                if (hold_cnt >= 50) ack_hold = 1'b0;
            end
        end else begin
            ack_hold = 1'b0;
        end
    end

    typedef struct {
        int            idx;
        logic [DW-1:0] dat;
        logic          err;
        int            hi_len;    // cycles hs_req stays high (-1: skip)
        int            done_lat;  // grant edge to done edge (-1: skip)
        int            rel;       // ack fall edge to done edge (-1: skip)
        int            period;    // grant edge to previous grant edge (-1: skip)
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mptr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: first pending requester after the last winner.
    function automatic int pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic push_exp(input int idx, input logic [DW-1:0] d, input logic e,
                            input int hl, input int dl, input int rl, input int per);
        exp_t x;
        x.idx = idx; x.dat = d; x.err = e;
        x.hi_len = hl; x.done_lat = dl; x.rel = rl; x.period = per;
        sb_q.push_back(x);
    endtask

    function automatic logic [DW-1:0] slot(input int i);
        return data[i*DW +: DW];
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) cyc <= cyc + 1;

    int   t_grant = -100, t_rise = -100, t_fall = -100, t_ackfall = -100, t_done = -100;
    logic p_ack = 1'b0, p_req = 1'b0;
    logic [N-1:0] p_grant = '0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!hs_ack && p_ack) t_ackfall = cyc;
        p_ack = hs_ack;
        if (rst) begin
            p_grant = grant;
            p_req   = hs_req;
        end else begin
            if (grant != 0 && p_grant == 0) begin
                chk("grant_busy", int'(busy), 1);
                chk("ack_quiet_before_grant", (cyc - t_ackfall >= S + 1) ? 1 : 0, 1);
                if (sb_q.size() == 0) begin
                    chk("unexpected_grant", int'(grant), 0);
                end else begin
                    chk("grant_onehot", int'(grant), 1 << sb_q[0].idx);
                    chk("hs_data_capture", int'(hs_data), int'(sb_q[0].dat));
                    if (sb_q[0].period >= 0) chk("period", cyc - t_grant, sb_q[0].period);
                end
                t_grant = cyc;
            end
            if (hs_req && !p_req) begin
                chk("req_after_setup", cyc - t_grant, 1);
                t_rise = cyc;
            end
            if (!hs_req && p_req) t_fall = cyc;
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("done_grant", int'(grant), 1 << mon_e.idx);
                    chk("done_hs_data", int'(hs_data), int'(mon_e.dat));
                    chk("done_err", int'(err), int'(mon_e.err));
                    chk("done_busy", int'(busy), 1);
                    chk("done_hs_req_low", int'(hs_req), 0);
                    if (mon_e.hi_len >= 0)   chk("req_high_len", t_fall - t_rise, mon_e.hi_len);
                    if (mon_e.done_lat >= 0) chk("grant_to_done", cyc - t_grant, mon_e.done_lat);
                    if (mon_e.rel >= 0)      chk("ackfall_to_done", cyc - t_ackfall, mon_e.rel);
                end
                t_done = cyc;
            end else if (err) begin
                chk("err_without_done", int'(err), 0);
            end
            if (grant == 0 && p_grant != 0) begin
                chk("grant_clear_after_done", cyc - t_done, 1);
                chk("idle_busy", int'(busy), 0);
            end
            p_grant = grant;
            p_req   = hs_req;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Waits for `count` done pulses; with drop set the finished requester
    // lowers its request, as a real requester would.
    task automatic wait_dones(input int count, input bit drop, input int budget);
        int seen = 0;
        int k    = 0;
        while (seen < count && k < budget) begin
            tick();
            k++;
            if (done) begin
                seen++;
                if (drop) req = req & ~grant;
            end
        end
        chk("wait_done", seen, count);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_grant"},   int'(grant),   0);
        chk({tag, "_done"},    int'(done),    0);
        chk({tag, "_err"},     int'(err),     0);
        chk({tag, "_busy"},    int'(busy),    0);
        chk({tag, "_hs_req"},  int'(hs_req),  0);
        chk({tag, "_hs_data"}, int'(hs_data), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int w, k, n;
        logic [N-1:0] m, mask;
        logic [DW-1:0] d;
        rst  = 1'b1;
        req  = '0;
        data = '0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst  = 1'b0;
        mptr = N - 1;

        // Single request, exact edge timing.
        data[2*DW +: DW] = 8'hA5;
        w = pick(4'b0100, mptr); mptr = w;
        push_exp(w, 8'hA5, 1'b0, S + 1, 2*S + 3, S + 1, -1);
        req = 4'b0100;
        wait_dones(1, 1'b1, 100);
        repeat (3) tick();

        // Fresh reset, then all four held high for eight transactions.
        rst = 1'b1; tick(); rst = 1'b0; mptr = N - 1;
        for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'($urandom);
        w = mptr;
        for (int i = 0; i < 8; i++) begin
            w = pick(4'b1111, w);
            push_exp(w, slot(w), 1'b0, S + 1, 2*S + 3, S + 1, (i == 0) ? -1 : 2*S + 5);
        end
        mptr = w;
        req = 4'b1111;
        wait_dones(8, 1'b0, 200);
        req = '0;
        repeat (3) tick();

        // Channel never acknowledges: timeout, then a normal transaction.
        ack_mode = 1;
        data[1*DW +: DW] = DW'($urandom);
        w = pick(4'b0010, mptr); mptr = w;
        push_exp(w, slot(w), 1'b1, T + 1, -1, -1, -1);
        req = 4'b0010;
        wait_dones(1, 1'b1, 100);
        ack_mode = 0;
        data[2*DW +: DW] = DW'($urandom);
        w = pick(4'b0100, mptr); mptr = w;
        push_exp(w, slot(w), 1'b0, S + 1, 2*S + 3, S + 1, -1);
        req = 4'b0100;
        wait_dones(1, 1'b1, 100);
        repeat (3) tick();

        // Acknowledge held high long after req falls: no timeout in REQ_LO.
        ack_mode = 2;
        data[3*DW +: DW] = DW'($urandom);
        w = pick(4'b1000, mptr); mptr = w;
        push_exp(w, slot(w), 1'b0, S + 1, -1, S + 1, -1);
        req = 4'b1000;
        wait_dones(1, 1'b1, 200);
        ack_mode = 0;
        repeat (3) tick();

        // Request dropped and data changed after grant.
        d = DW'($urandom);
        data[0 +: DW] = d;
        w = pick(4'b0001, mptr); mptr = w;
        push_exp(w, d, 1'b0, S + 1, 2*S + 3, S + 1, -1);
        req = 4'b0001;
        k = 0;
        while (grant == 0 && k < 20) begin tick(); k++; end
        chk("grant_seen", (grant != 0) ? 1 : 0, 1);
        req = '0;
        data[0 +: DW] = ~d;
        wait_dones(1, 1'b1, 100);
        repeat (3) tick();

        // Reset mid-transaction while hs_req and hs_ack are both high.
        data[3*DW +: DW] = DW'($urandom);
        data[0 +: DW]    = DW'($urandom);
        push_exp(pick(4'b1000, mptr), slot(3), 1'b0, -1, -1, -1, -1);
        req = 4'b1000;
        k = 0;
        while (!(hs_req && hs_ack) && k < 20) begin tick(); k++; end
        chk("reached_req_ack_high", (hs_req && hs_ack) ? 1 : 0, 1);
        rst = 1'b1;
        tick();
        check_outputs_zero("midreset");
        req = 4'b1001;
        tick(); chk("reset_hold_grant", int'(grant), 0);
        tick(); chk("reset_hold_grant", int'(grant), 0);
        sb_q.delete();
        mptr = N - 1;
        w = pick(4'b1001, mptr);
        push_exp(w, slot(w), 1'b0, S + 1, 2*S + 3, S + 1, -1);
        w = pick(4'b1001 & ~(4'b0001 << w), w);
        push_exp(w, slot(w), 1'b0, S + 1, 2*S + 3, S + 1, -1);
        mptr = w;
        rst = 1'b0;
        wait_dones(2, 1'b1, 100);
        repeat (3) tick();

        // Randomised request sets against the round-robin reference.
        for (int r = 0; r < 10; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                if (mask[i]) data[i*DW +: DW] = DW'($urandom);
            m = mask;
            n = 0;
            while (m != 0) begin
                w = pick(m, mptr);
                push_exp(w, slot(w), 1'b0, S + 1, 2*S + 3, S + 1, -1);
                m[w] = 1'b0;
                mptr = w;
                n++;
            end
            req = mask;
            wait_dones(n, 1'b1, n * 20 + 20);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
